// File: rtl/cpu_pkg.sv
// Definitions shared between the divider and the control unit:
// divider FSM states and the iteration count constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DIV_ITER  = 32;
    localparam int DIV_CNT_W = 5;

    // True on the counter value of the final restoring iteration.
    function automatic logic div_last_iter(input logic [DIV_CNT_W-1:0] cnt);
        return cnt == DIV_CNT_W'(DIV_ITER - 1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor at WIDTH+1 bits, keep the difference only if it is non-negative.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvsr_i};
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider (MIPS div): 32 restoring iterations on magnitudes,
// then a sign-fix cycle. Remainder drives the Hi path, quotient the Lo path.
module seq_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_ctrl,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_end,
    output logic             div_zero,
    output logic             busy
);

    div_state_e             state_q;
    logic [DIV_CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]       rem_q, quo_q, dvsr_q;
    logic                   neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0]       hi_q, lo_q;
    logic                   end_q, zero_q, busy_q;

    logic [WIDTH-1:0]       rem_d, quo_d;
    logic [WIDTH-1:0]       a_abs, b_abs;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    assign a_abs = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_abs = b_in[WIDTH-1] ? -b_in : b_in;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (rem_d),
        .quo_o  (quo_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            end_q     <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    end_q <= 1'b0;
                    if (div_ctrl) begin
                        busy_q <= 1'b1;
                        if (b_in == '0) begin
                            // Hi/Lo are left untouched so the exception
                            // handler still sees the previous result.
                            zero_q  <= 1'b1;
                            end_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            zero_q    <= 1'b0;
                            rem_q     <= '0;
                            quo_q     <= a_abs;
                            dvsr_q    <= b_abs;
                            neg_quo_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            neg_rem_q <= a_in[WIDTH-1];
                            cnt_q     <= '0;
                            state_q   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + DIV_CNT_W'(1);
                    if (div_last_iter(cnt_q)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    lo_q    <= neg_quo_q ? -quo_q : quo_q;
                    hi_q    <= neg_rem_q ? -rem_q : rem_q;
                    end_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    end_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    end_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign div_end  = end_q;
    assign div_zero = zero_q;
    assign busy     = busy_q;

endmodule
